// File: rtl/lsu_stage.sv
// rtl/lsu_stage.sv - load/store stage: memory request/grant/response, lane alignment, load extension
module lsu_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [4:0]  rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misaligned
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d, sd_q, sd_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d, load_q, load_d;
    logic [4:0]  rd_q, rd_d;
    logic        wb_valid_q, wb_valid_d, wb_we_q, wb_we_d, mis_q, mis_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;

    logic        mem_op, fault, in_req;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, ld_ext;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign mem_op = is_load | is_store;

    always_comb begin
        fault = 1'b0;
        case (mem_size)
            2'b01:   fault = alu_result[0];
            2'b10:   fault = |alu_result[1:0];
            2'b11:   fault = 1'b1;
            default: fault = 1'b0;
        endcase
    end

    // Lane steering works from the latched request so it stays stable while REQ waits for grant
    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = sd_q;
        case (size_q)
            2'b00: begin
                lane_be    = 4'b0001 << addr_q[1:0];
                lane_wdata = {4{sd_q[7:0]}};
            end
            2'b01: begin
                lane_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{sd_q[15:0]}};
            end
            default: begin
                lane_be    = 4'b1111;
                lane_wdata = sd_q;
            end
        endcase
    end

    always_comb begin
        ld_byte = dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (size_q)
            2'b00:   ld_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
            default: ld_ext = dmem_rdata;
        endcase
    end

    assign in_req     = (state_q == REQ);
    assign ex_ready   = (state_q == IDLE);
    assign dmem_req   = in_req;
    assign dmem_we    = in_req & ~load_q;
    assign dmem_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign dmem_be    = in_req ? lane_be : 4'd0;
    assign dmem_wdata = in_req ? lane_wdata : 32'd0;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        sd_d       = sd_q;
        size_d     = size_q;
        uns_d      = uns_q;
        load_d     = load_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_we_d    = wb_we_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        mis_d      = mis_q;
        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (mem_op && !fault) begin
                        addr_d  = alu_result;
                        sd_d    = store_data;
                        size_d  = mem_size;
                        uns_d   = mem_unsigned;
                        load_d  = is_load;
                        rd_d    = rd;
                        state_d = REQ;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_we_d    = ~mem_op;
                        mis_d      = mem_op;
                        wb_data_d  = alu_result;
                        wb_rd_d    = rd;
                    end
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    if (load_q) begin
                        state_d = WAIT;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_we_d    = 1'b0;
                        mis_d      = 1'b0;
                        wb_data_d  = addr_q;
                        wb_rd_d    = rd_q;
                        state_d    = IDLE;
                    end
                end
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    wb_valid_d = 1'b1;
                    wb_we_d    = 1'b1;
                    mis_d      = 1'b0;
                    wb_data_d  = ld_ext;
                    wb_rd_d    = rd_q;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= 32'd0;
            sd_q       <= 32'd0;
            size_q     <= 2'd0;
            uns_q      <= 1'b0;
            load_q     <= 1'b0;
            rd_q       <= 5'd0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'd0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            sd_q       <= sd_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            load_q     <= load_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            mis_q      <= mis_d;
        end
    end

    assign wb_valid   = wb_valid_q;
    assign wb_we      = wb_we_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign misaligned = mis_q;
endmodule

// File: tb/tb_lsu_stage.sv
// tb/tb_lsu_stage.sv - directed self-checking bench for lsu_stage
module tb_lsu_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [31:0] alu_result = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [1:0]  mem_size = 2'd0;
    logic        mem_unsigned = 1'b0;
    logic [4:0]  rd = 5'd0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = 32'd0;
    logic        wb_valid, wb_we, misaligned;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lsu_stage dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .alu_result(alu_result), .store_data(store_data), .is_load(is_load),
        .is_store(is_store), .mem_size(mem_size), .mem_unsigned(mem_unsigned), .rd(rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .misaligned(misaligned)
    );

    task automatic test_reset();
        #1;
        checks++;
        if ({ex_ready, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata} !== {1'b1, 70'd0}) begin
            fails++;
            $display("FAIL reset_mem: ready=%b req=%b we=%b be=%b addr=%h wdata=%h required ready=1 others 0",
                     ex_ready, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata);
        end
        checks++;
        if ({wb_valid, wb_we, wb_rd, wb_data, misaligned} !== 40'd0) begin
            fails++;
            $display("FAIL reset_wb: valid=%b we=%b rd=%0d data=%h mis=%b required all 0",
                     wb_valid, wb_we, wb_rd, wb_data, misaligned);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_pass_through();
        @(negedge clk);
        ex_valid = 1'b1; alu_result = 32'h3; rd = 5'd5;
        is_load = 1'b0; is_store = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({wb_valid, wb_we, wb_rd, wb_data, misaligned, dmem_req} !== {1'b1, 1'b1, 5'd5, 32'h3, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL pass_through[%0d]: valid=%b we=%b rd=%0d data=%h mis=%b req=%b required 1 1 5 00000003 0 0",
                         i, wb_valid, wb_we, wb_rd, wb_data, misaligned, dmem_req);
            end
            if (i == 2) ex_valid = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0) begin
            fails++;
            $display("FAIL pass_through_end: wb_valid=%b required 0", wb_valid);
        end
    endtask

    task automatic test_store_byte();
        @(negedge clk);
        ex_valid = 1'b1; is_store = 1'b1; is_load = 1'b0; alu_result = 32'h102;
        store_data = 32'h000000AB; mem_size = 2'b00; rd = 5'd7; dmem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ex_valid = 1'b0;
            #1;
            checks++;
            if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, ex_ready, wb_valid} !==
                {1'b1, 1'b1, 4'b0100, 32'h100, 32'hABABABAB, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL store_req[%0d]: req=%b we=%b be=%b addr=%h wdata=%h ready=%b wbv=%b required 1 1 0100 00000100 abababab 0 0",
                         i, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, ex_ready, wb_valid);
            end
            if (i == 2) dmem_gnt = 1'b1;
        end
        @(negedge clk);
        dmem_gnt = 1'b0;
        #1;
        checks++;
        if ({wb_valid, wb_we, misaligned, dmem_req, dmem_be, ex_ready} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1}) begin
            fails++;
            $display("FAIL store_wb: valid=%b we=%b mis=%b req=%b be=%b ready=%b required 1 0 0 0 0000 1",
                     wb_valid, wb_we, misaligned, dmem_req, dmem_be, ex_ready);
        end
        is_store = 1'b0;
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0) begin
            fails++;
            $display("FAIL store_pulse: wb_valid=%b required 0", wb_valid);
        end
    endtask

    task automatic test_load(input string name, input logic [31:0] addr, input logic [1:0] size,
                             input logic uns, input logic [31:0] rdata, input logic [31:0] expected);
        @(negedge clk);
        ex_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; alu_result = addr;
        mem_size = size; mem_unsigned = uns; rd = 5'd9;
        @(negedge clk);
        ex_valid = 1'b0; mem_unsigned = 1'b0;
        #1;
        checks++;
        if ({dmem_req, dmem_we, dmem_addr} !== {1'b1, 1'b0, addr[31:2], 2'b00}) begin
            fails++;
            $display("FAIL %s_req: req=%b we=%b addr=%h required 1 0 %h",
                     name, dmem_req, dmem_we, dmem_addr, {addr[31:2], 2'b00});
        end
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        #1;
        checks++;
        if ({dmem_req, dmem_be, wb_valid} !== 6'd0) begin
            fails++;
            $display("FAIL %s_wait: req=%b be=%b wbv=%b required 0 0000 0", name, dmem_req, dmem_be, wb_valid);
        end
        @(negedge clk);
        dmem_rvalid = 1'b1; dmem_rdata = rdata;
        @(negedge clk);
        dmem_rvalid = 1'b0; is_load = 1'b0;
        checks++;
        if ({wb_valid, wb_we, wb_rd, wb_data, misaligned} !== {1'b1, 1'b1, 5'd9, expected, 1'b0}) begin
            fails++;
            $display("FAIL %s_data: valid=%b we=%b rd=%0d data=%h mis=%b required 1 1 9 %h 0",
                     name, wb_valid, wb_we, wb_rd, wb_data, misaligned, expected);
        end
    endtask

    task automatic test_misaligned();
        @(negedge clk);
        ex_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; alu_result = 32'h6; mem_size = 2'b10; rd = 5'd3;
        @(negedge clk);
        checks++;
        if ({dmem_req, wb_valid, misaligned, wb_we, wb_data, ex_ready} !== {1'b0, 1'b1, 1'b1, 1'b0, 32'h6, 1'b1}) begin
            fails++;
            $display("FAIL misaligned_word: req=%b valid=%b mis=%b we=%b data=%h ready=%b required 0 1 1 0 00000006 1",
                     dmem_req, wb_valid, misaligned, wb_we, wb_data, ex_ready);
        end
        is_load = 1'b0; alu_result = 32'h9; mem_size = 2'b00;
        @(negedge clk);
        ex_valid = 1'b0;
        checks++;
        if ({wb_valid, misaligned, wb_we, wb_data} !== {1'b1, 1'b0, 1'b1, 32'h9}) begin
            fails++;
            $display("FAIL misaligned_clear: valid=%b mis=%b we=%b data=%h required 1 0 1 00000009",
                     wb_valid, misaligned, wb_we, wb_data);
        end
        ex_valid = 1'b1; is_store = 1'b1; alu_result = 32'h0; mem_size = 2'b11;
        @(negedge clk);
        ex_valid = 1'b0; is_store = 1'b0; mem_size = 2'b00;
        checks++;
        if ({dmem_req, wb_valid, misaligned, wb_we} !== 4'b0110) begin
            fails++;
            $display("FAIL reserved_size: req=%b valid=%b mis=%b we=%b required 0 1 1 0",
                     dmem_req, wb_valid, misaligned, wb_we);
        end
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        ex_valid = 1'b1; is_load = 1'b1; alu_result = 32'h4; mem_size = 2'b10; rd = 5'd12;
        @(negedge clk);
        ex_valid = 1'b0; dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0; is_load = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({ex_ready, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, wb_valid, wb_we, wb_rd, wb_data, misaligned} !==
            {1'b1, 110'd0}) begin
            fails++;
            $display("FAIL reset_wait_outputs: ready=%b req=%b be=%b addr=%h wbv=%b data=%h mis=%b required ready=1 others 0",
                     ex_ready, dmem_req, dmem_be, dmem_addr, wb_valid, wb_data, misaligned);
        end
        @(negedge clk);
        rst = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        checks++;
        if ({wb_valid, ex_ready, dmem_req, wb_data} !== {1'b0, 1'b1, 1'b0, 32'd0}) begin
            fails++;
            $display("FAIL reset_wait_late_rvalid: wbv=%b ready=%b req=%b data=%h required 0 1 0 00000000",
                     wb_valid, ex_ready, dmem_req, wb_data);
        end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_store_byte();
        test_load("load_half_s", 32'h22, 2'b01, 1'b0, 32'h8001_1234, 32'hFFFF8001);
        test_load("load_half_u", 32'h22, 2'b01, 1'b1, 32'h8001_1234, 32'h00008001);
        test_load("load_byte", 32'h1, 2'b00, 1'b0, 32'h11227F33, 32'h0000007F);
        test_load("load_byte_s", 32'h3, 2'b00, 1'b0, 32'h80227F33, 32'hFFFFFF80);
        test_load("load_word", 32'h8, 2'b10, 1'b1, 32'h89ABCDEF, 32'h89ABCDEF);
        test_misaligned();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/lsu_stage.md
Name: lsu_stage

Overview:
- Load/store stage directly downstream of the execute-stage ALU.
- Consumes the ALU result as an effective address for loads and stores, and as pass-through data for all other instructions.
- Drives a request/grant/response data-memory port and aligns the store byte lanes.
- Extracts and extends load data, then presents one registered result per instruction to writeback.

Parameters:
- None. Data and address widths are fixed at 32 bits; register index width is fixed at 5 bits.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
ex_valid  in  1  execute stage presents an instruction
ex_ready  out  1  stage can accept; combinational, equals (state==IDLE)
alu_result  in  32  ALU output; used as address for loads/stores, as data otherwise
store_data  in  32  rs2 value for stores
is_load  in  1  instruction is a load
is_store  in  1  instruction is a store
mem_size  in  2  00 byte, 01 half, 10 word, 11 reserved
mem_unsigned  in  1  zero-extend loads when 1
rd  in  5  destination register index
dmem_req  out  1  memory request
dmem_we  out  1  1 = write
dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_gnt  in  1  request accepted this cycle
dmem_rvalid  in  1  read data valid
dmem_rdata  in  32  read data
wb_valid  out  1  one-cycle result pulse
wb_we  out  1  register write enable (0 for stores and faults)
wb_rd  out  5  destination index
wb_data  out  32  result
misaligned  out  1  fault flag, qualified by wb_valid

Behaviour:
- Reset: state=IDLE. All outputs 0 except ex_ready=1.
- Reset is honoured mid-transaction: any pending request is dropped and no wb_valid is produced.
- Accept condition: ex_valid && ex_ready. Inputs are latched on the accept edge.
- is_load has priority if both is_load and is_store are set.
- Non-memory op:
  - Next cycle: wb_valid=1, wb_we=1, wb_data=alu_result, wb_rd=rd; state stays IDLE.
  - Throughput is 1 per cycle.
- Fault: half with addr[0]=1, word with addr[1:0]!=0, or mem_size=11.
  - No memory access.
  - Next cycle: wb_valid=1, misaligned=1, wb_we=0, wb_data=alu_result.
- Valid load/store: go to REQ; ex_ready=0.
- REQ state:
  - dmem_req=1; addr, we, be and wdata are held stable until dmem_gnt=1 is sampled.
  - Store + gnt: next cycle wb_valid=1, wb_we=0; go to IDLE.
  - Load + gnt: go to WAIT.
  - dmem_rvalid is ignored in REQ.
- WAIT state:
  - dmem_req=0.
  - On dmem_rvalid: wb_valid=1, wb_we=1, wb_data = extracted and extended value; go to IDLE.
  - No timeout.
- Byte lanes (a = addr[1:0]):
  - byte: be = 1<<a, wdata = {4{sd[7:0]}}, load takes rdata[8a+7:8a].
  - half: be = a[1] ? 1100 : 0011, wdata = {2{sd[15:0]}}, load takes the upper or lower half.
  - word: be = 1111.
- Extension: sign-extend unless mem_unsigned=1. Word loads ignore mem_unsigned.
- wb_valid is a registered single-cycle pulse. misaligned is cleared on every non-fault wb_valid.
- Returning to IDLE coincides with the wb_valid edge, so the next instruction is accepted in the cycle wb_valid is high.
- dmem_we and dmem_be are 0 whenever dmem_req=0.

Test Plan:
- Pass-through: ALU op alu_result=0x00000003, rd=5 on three consecutive cycles -> wb_valid high three consecutive cycles, wb_data=3, wb_rd=5, no dmem_req.
- Store byte: addr=0x102, sd=0x000000AB, size=00, gnt delayed 2 cycles -> dmem_req held 3 cycles, be=0100, wdata=0xABABABAB, dmem_addr=0x100, then wb_valid with wb_we=0.
- Signed half load: addr=0x22, rdata=0x8001_1234, gnt immediate, rvalid 2 cycles later -> wb_data=0xFFFF8001. Same with mem_unsigned=1 -> 0x00008001.
- Byte load: addr=0x1, rdata=0x11227F33 -> wb_data=0x0000007F, wb_we=1.
- Misaligned word: addr=0x6 -> no dmem_req; next cycle wb_valid=1, misaligned=1, wb_we=0. The following ALU op clears misaligned.
- Reset in WAIT: assert rst between gnt and rvalid, then a late rvalid arrives -> all outputs 0, ex_ready=1, no wb_valid.
